// File: rtl/bcd_decrement_seq.sv
// bcd_decrement_seq: digit-serial packed-BCD decrement by one, LSD first; define BCD_DEC_SATURATE_EN to saturate all-zero input at zero
module bcd_decrement_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_value,
    output logic                out_borrow,
    output logic                out_invalid
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    state_t state;
    logic [IW-1:0] idx;
    logic [3:0] d;
    logic bad;
    assign in_ready = state == IDLE;
    assign d = out_value[{idx, 2'b00} +: 4];
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (in_value[4*i +: 4] > 4'd9);
    end
    // out_value doubles as the work register; the borrow walks it one nibble per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            out_value   <= '0;
            out_valid   <= 1'b0;
            out_borrow  <= 1'b0;
            out_invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    out_value   <= in_value;
                    idx         <= '0;
                    out_borrow  <= 1'b0;
                    out_invalid <= bad;
                    state       <= bad ? DONE : CALC;
                end
                CALC: if (d != 4'd0) begin
                    out_value[{idx, 2'b00} +: 4] <= d - 4'd1;
                    state <= DONE;
                end else if (idx == IW'(DIGITS - 1)) begin
`ifdef BCD_DEC_SATURATE_EN
                    out_value <= '0;
`else
                    out_value[{idx, 2'b00} +: 4] <= 4'd9;
`endif
                    out_borrow <= 1'b1;
                    state      <= DONE;
                end else begin
                    out_value[{idx, 2'b00} +: 4] <= 4'd9;
                    idx <= idx + 1'b1;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_decrement_seq.sv
// tb_bcd_decrement_seq: directed and randomized checks of bcd_decrement_seq against a decimal-arithmetic model
module tb_bcd_decrement_seq;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_value;
    logic        out_borrow;
    logic        out_invalid;
    int total = 0;
    int bad = 0;

    bcd_decrement_seq #(.DIGITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_borrow(out_borrow), .out_invalid(out_invalid)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [15:0] v, output logic [15:0] r,
                                  output logic b, output logic inv, output int lat);
        int n, m, tz;
        logic [3:0] dg;
        inv = 0;
        n = 0;
        tz = 0;
        for (int i = 3; i >= 0; i--) begin
            dg = v[i*4 +: 4];
            if (dg > 9) inv = 1;
            n = n * 10 + int'(dg);
        end
        for (int i = 0; i < 4; i++) begin
            dg = v[i*4 +: 4];
            if (dg != 0) break;
            tz++;
        end
        r = v;
        b = 0;
        lat = 1;
        if (inv) return;
        lat = (tz + 1 > 4 ? 4 : tz + 1) + 1;
        if (n == 0) begin
            b = 1;
`ifdef BCD_DEC_SATURATE_EN
            m = 0;
`else
            m = 9999;
`endif
        end else m = n - 1;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic run_word(input logic [15:0] v, input string tag);
        logic [15:0] er;
        logic eb, ei;
        int el, cyc;
        model(v, er, eb, ei, el);
        in_value = v;
        in_valid = 1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (cyc !== el) begin
            bad++; $display("FAIL %s latency in=%h got %0d exp %0d", tag, v, cyc, el);
        end
        total++;
        if (out_value !== er) begin
            bad++; $display("FAIL %s value in=%h got %h exp %h", tag, v, out_value, er);
        end
        total++;
        if (out_borrow !== eb || out_invalid !== ei) begin
            bad++; $display("FAIL %s flags in=%h got b=%b i=%b exp b=%b i=%b",
                            tag, v, out_borrow, out_invalid, eb, ei);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++;
        if (out_valid !== 0 || in_ready !== 1) begin
            bad++; $display("FAIL %s release got valid=%b ready=%b exp 0 1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        total++;
        if (in_ready !== 1 || out_valid !== 0 || out_value !== 16'h0 ||
            out_borrow !== 0 || out_invalid !== 0) begin
            bad++; $display("FAIL reset got rdy=%b vld=%b val=%h b=%b i=%b exp 1 0 0000 0 0",
                            in_ready, out_valid, out_value, out_borrow, out_invalid);
        end
    endtask

    task automatic test_directed();
        run_word(16'h1235, "dir_1235");
        run_word(16'h8900, "dir_8900");
        run_word(16'h0000, "dir_zero");
        run_word(16'h12A4, "dir_invalid");
        run_word(16'h9999, "dir_9999");
        run_word(16'h0010, "dir_0010");
    endtask

    task automatic test_hold();
        int cyc;
        in_value = 16'h1000;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        in_value = 16'h5555;
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1 || out_value !== 16'h0999 || in_ready !== 0 || out_borrow !== 0) begin
                bad++; $display("FAIL hold cycle %0d got vld=%b val=%h rdy=%b b=%b exp 1 0999 0 0",
                                i, out_valid, out_value, in_ready, out_borrow);
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        total++;
        if (out_valid !== 0 || in_ready !== 1) begin
            bad++; $display("FAIL hold_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        in_value = 16'h7000;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        total++;
        if (in_ready !== 1 || out_valid !== 0 || out_value !== 16'h0 ||
            out_borrow !== 0 || out_invalid !== 0) begin
            bad++; $display("FAIL abort got rdy=%b vld=%b val=%h b=%b i=%b exp 1 0 0000 0 0",
                            in_ready, out_valid, out_value, out_borrow, out_invalid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 0) begin
                bad++; $display("FAIL abort_quiet cycle %0d got vld=%b exp 0", i, out_valid);
            end
        end
        run_word(16'h0001, "abort_next");
    endtask

    task automatic test_random();
        logic [15:0] v;
        int r;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 31));
                v[i*4 +: 4] = r < 10 ? 4'd0 : r < 30 ? 4'((r - 10) % 10) : 4'($urandom_range(10, 15));
            end
            run_word(v, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
